// File: rtl/pim_out_stream_buffer.sv
// PIM output stream buffer: two-phase capture of the wide ADC result, per-channel
// accumulation, zero-point correction with saturation, and a valid/ready word drain.
module pim_out_stream_buffer #(
    parameter int unsigned NUM_CH        = 32,
    parameter int unsigned DATA_W        = 32,
    parameter bit          DRAIN_REVERSE = 1'b1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NUM_CH*DATA_W-1:0]    pim_data_i,
    input  logic [2:0]                  mode_i,
    input  logic                        cap1_i,
    input  logic                        cap2_i,
    input  logic                        drain_i,
    input  logic                        flush_i,
    input  logic [$clog2(NUM_CH)-1:0]   col_addr_i,
    input  logic                        zp_en_i,
    input  logic [DATA_W-1:0]           zp_data_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [DATA_W-1:0]           out_data_o,
    output logic                        out_last_o,
    output logic                        done_o,
    output logic                        full_o,
    output logic                        err_o
);

    localparam int unsigned PIM_W = NUM_CH * DATA_W;
    localparam int unsigned CH_W  = $clog2(NUM_CH);

    localparam logic [2:0] MODE_READ     = 3'b011;
    localparam logic [2:0] MODE_PARALLEL = 3'b101;
    localparam logic [2:0] MODE_RBR      = 3'b110;

    // First and final channel of a full drain
    localparam logic [CH_W-1:0] IDX_FIRST = DRAIN_REVERSE ? CH_W'(NUM_CH - 1) : CH_W'(0);
    localparam logic [CH_W-1:0] IDX_END   = DRAIN_REVERSE ? CH_W'(0) : CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] ch_c  [NUM_CH];
    logic [DATA_W-1:0] acc_q [NUM_CH];

    logic [DATA_W-1:0] zp_shadow_q;
    logic [DATA_W-1:0] zp_active_q;
    logic [CH_W-1:0]   idx_q;

    logic              valid_q;
    logic              last_q;
    logic [DATA_W-1:0] data_q;
    logic              done_q;
    logic              full_q;
    logic              err_q;

    logic              acc_load;
    logic              acc_add;
    logic              err_set;
    logic              drain_start;
    logic              step;
    logic              finish;

    logic              mode_ok;
    logic              read_sel;
    logic              handshake;
    logic [CH_W-1:0]   start_idx;
    logic [CH_W-1:0]   step_idx;
    logic [CH_W-1:0]   sel_idx;
    logic [DATA_W-1:0] sel_zp;
    logic [DATA_W-1:0] word_c;
    logic              last_next;

    // Signed a-b evaluated one bit wider, clamped to the DATA_W signed range
    function automatic logic [DATA_W-1:0] sat_sub(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [DATA_W:0] diff;
        diff = {a[DATA_W-1], a} - {b[DATA_W-1], b};
        if (diff[DATA_W] != diff[DATA_W-1]) begin
            sat_sub = diff[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            sat_sub = diff[DATA_W-1:0];
        end
    endfunction

    // Channel c sits at the MSB end of the ADC bus for c = 0
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign ch_c[g] = pim_data_i[PIM_W-1-g*DATA_W -: DATA_W];
    end

    assign mode_ok   = (mode_i == MODE_READ) || (mode_i == MODE_PARALLEL) || (mode_i == MODE_RBR);
    assign read_sel  = (mode_i == MODE_READ);
    assign handshake = valid_q & out_ready_i;
    assign start_idx = read_sel ? col_addr_i : IDX_FIRST;
    assign step_idx  = DRAIN_REVERSE ? (idx_q - CH_W'(1)) : (idx_q + CH_W'(1));

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control strobes; flush overrides every other event
    always_comb begin
        state_d     = state_q;
        acc_load    = 1'b0;
        acc_add     = 1'b0;
        err_set     = 1'b0;
        drain_start = 1'b0;
        step        = 1'b0;
        finish      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cap1_i && cap2_i) begin
                    err_set = 1'b1;
                end else if (cap1_i) begin
                    acc_load = 1'b1;
                    state_d  = ST_HALF;
                end else if (cap2_i) begin
                    err_set = 1'b1;
                end
                if (drain_i) begin
                    err_set = 1'b1;
                end
            end
            ST_HALF: begin
                if (cap1_i && cap2_i) begin
                    err_set = 1'b1;
                end else if (cap2_i) begin
                    acc_add = 1'b1;
                    state_d = ST_FULL;
                end else if (cap1_i) begin
                    acc_load = 1'b1;
                end
                if (drain_i) begin
                    err_set = 1'b1;
                end
            end
            ST_FULL: begin
                if (cap1_i || cap2_i) begin
                    err_set = 1'b1;
                end
                if (drain_i) begin
                    if (mode_ok) begin
                        drain_start = 1'b1;
                        state_d     = ST_DRAIN;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (cap1_i || cap2_i || drain_i) begin
                    err_set = 1'b1;
                end
                if (handshake) begin
                    if (last_q) begin
                        finish  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        step = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (flush_i) begin
            state_d     = ST_IDLE;
            acc_load    = 1'b0;
            acc_add     = 1'b0;
            err_set     = 1'b0;
            drain_start = 1'b0;
            step        = 1'b0;
            finish      = 1'b0;
        end
    end

    // Word to present next: first word uses the zero point being latched now
    always_comb begin
        sel_idx   = drain_start ? start_idx : step_idx;
        sel_zp    = drain_start ? zp_shadow_q : zp_active_q;
        word_c    = sat_sub(acc_q[sel_idx], sel_zp);
        last_next = drain_start ? (read_sel || (start_idx == IDX_END)) : (step_idx == IDX_END);
    end

    // Per-channel accumulators; phase-2 addition wraps
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < NUM_CH; c++) begin
                acc_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (acc_load) begin
                    acc_q[c] <= ch_c[c];
                end else if (acc_add) begin
                    acc_q[c] <= acc_q[c] + ch_c[c];
                end
            end
        end
    end

    // Zero point, drain pointer and registered stream/status outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            zp_shadow_q <= '0;
            zp_active_q <= '0;
            idx_q       <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            data_q      <= '0;
            done_q      <= 1'b0;
            full_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (zp_en_i) begin
                zp_shadow_q <= zp_data_i;
            end

            done_q <= finish;
            full_q <= (state_d == ST_FULL);

            if (flush_i) begin
                err_q <= 1'b0;
            end else if (err_set) begin
                err_q <= 1'b1;
            end

            if (flush_i || finish) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
                data_q  <= '0;
            end else if (drain_start || step) begin
                valid_q <= 1'b1;
                last_q  <= last_next;
                data_q  <= word_c;
            end

            if (drain_start) begin
                idx_q       <= start_idx;
                zp_active_q <= zp_shadow_q;
            end else if (step) begin
                idx_q <= step_idx;
            end
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_last_o  = last_q;
    assign done_o      = done_q;
    assign full_o      = full_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_pim_out_stream_buffer.sv
// Randomized bench for pim_out_stream_buffer against a queue-based word model.
module tb_pim_out_stream_buffer;

    localparam int unsigned NUM_CH  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned PIM_W   = NUM_CH * DATA_W;
    localparam int unsigned CH_W    = $clog2(NUM_CH);
    localparam bit          REV     = 1'b1;

    localparam logic [2:0] MODE_READ     = 3'b011;
    localparam logic [2:0] MODE_PARALLEL = 3'b101;
    localparam logic [2:0] MODE_RBR      = 3'b110;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [PIM_W-1:0]  pim_data;
    logic [2:0]        mode;
    logic              cap1;
    logic              cap2;
    logic              drain;
    logic              flush;
    logic [CH_W-1:0]   col_addr;
    logic              zp_en;
    logic [DATA_W-1:0] zp_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              done;
    logic              full;
    logic              err;

    int checks   = 0;
    int failures = 0;

    // Reference state: accumulated channel values and pending zero point
    logic [DATA_W-1:0] m_acc   [NUM_CH];
    logic [DATA_W-1:0] m_zp;
    logic [DATA_W-1:0] stim_ch [NUM_CH];

    pim_out_stream_buffer #(
        .NUM_CH        (NUM_CH),
        .DATA_W        (DATA_W),
        .DRAIN_REVERSE (REV)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .pim_data_i  (pim_data),
        .mode_i      (mode),
        .cap1_i      (cap1),
        .cap2_i      (cap2),
        .drain_i     (drain),
        .flush_i     (flush),
        .col_addr_i  (col_addr),
        .zp_en_i     (zp_en),
        .zp_data_i   (zp_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
        .done_o      (done),
        .full_o      (full),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected stream word: signed difference clamped to the DATA_W range
    function automatic logic [DATA_W-1:0] model_word(input logic [DATA_W-1:0] a,
                                                     input logic [DATA_W-1:0] z);
        longint d;
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (DATA_W - 1)) - 1;
        lo = -(longint'(1) <<< (DATA_W - 1));
        d  = longint'($signed(a)) - longint'($signed(z));
        if (d > hi) d = hi;
        if (d < lo) d = lo;
        return DATA_W'(d);
    endfunction

    task automatic capture(input bit second);
        for (int c = 0; c < NUM_CH; c++) begin
            pim_data[PIM_W-1-c*DATA_W -: DATA_W] = stim_ch[c];
        end
        cap1 = !second;
        cap2 = second;
        tick();
        cap1 = 1'b0;
        cap2 = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (second) m_acc[c] = m_acc[c] + stim_ch[c];
            else        m_acc[c] = stim_ch[c];
        end
    endtask

    task automatic rand_stim();
        for (int c = 0; c < NUM_CH; c++) stim_ch[c] = $urandom;
    endtask

    task automatic load_zp(input logic [DATA_W-1:0] z);
        zp_en   = 1'b1;
        zp_data = z;
        tick();
        zp_en   = 1'b0;
        m_zp    = z;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    // rmode: 0 always ready, 1 pattern 1,0,0,1, 2 random
    task automatic run_drain(input logic [2:0] md, input int col, input int rmode,
                             input bit zp_mid, input logic [DATA_W-1:0] zp_new);
        logic [DATA_W-1:0] exp_q[$];
        logic [DATA_W-1:0] prev_data;
        logic              prev_last;
        bit                stalled;
        bit                rdy;
        int                n;
        int                k;
        int                cyc;

        if (md == MODE_READ) begin
            exp_q.push_back(model_word(m_acc[col], m_zp));
        end else begin
            for (int j = 0; j < NUM_CH; j++) begin
                exp_q.push_back(model_word(m_acc[REV ? NUM_CH - 1 - j : j], m_zp));
            end
        end
        n = exp_q.size();

        mode     = md;
        col_addr = CH_W'(col);
        drain    = 1'b1;
        tick();
        drain    = 1'b0;
        mode     = 3'b000;
        check("first_valid", out_valid, 1);

        k = 0;
        cyc = 0;
        stalled = 1'b0;
        prev_data = '0;
        prev_last = 1'b0;
        while (k < n && cyc < 8 * n + 16) begin
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            out_ready = rdy;
            zp_en = zp_mid && (cyc == 3);
            if (zp_en) begin
                zp_data = zp_new;
                m_zp    = zp_new;
            end
            check("valid", out_valid, 1);
            check("word", out_data, exp_q[k]);
            check("last", out_last, k == n - 1);
            if (stalled) begin
                check("hold_data", out_data, prev_data);
                check("hold_last", out_last, prev_last);
            end
            prev_data = out_data;
            prev_last = out_last;
            stalled   = !rdy;
            if (rdy) k++;
            tick();
            cyc++;
        end
        zp_en     = 1'b0;
        out_ready = 1'b0;
        if (k < n) check("drain_timeout", 64'(k), 64'(n));
        check("end_valid", out_valid, 0);
        check("end_data", out_data, 0);
        check("done", done, 1);
        check("end_full", full, 0);
        check("end_err", err, 0);
        tick();
        check("done_pulse", done, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        pim_data  = '0;
        mode      = 3'b000;
        cap1      = 1'b0;
        cap2      = 1'b0;
        drain     = 1'b0;
        flush     = 1'b0;
        col_addr  = '0;
        zp_en     = 1'b0;
        zp_data   = '0;
        out_ready = 1'b0;
        m_zp      = '0;
        for (int c = 0; c < NUM_CH; c++) m_acc[c] = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_last", out_last, 0);
        check("rst_done", done, 0);
        check("rst_full", full, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        tick();

        // Two-phase: ch c = c then +2, reverse drain gives 33 down to 2
        for (int c = 0; c < NUM_CH; c++) stim_ch[c] = DATA_W'(c);
        capture(1'b0);
        check("half_not_full", full, 0);
        for (int c = 0; c < NUM_CH; c++) stim_ch[c] = DATA_W'(2);
        capture(1'b1);
        check("full", full, 1);
        check("acc31", m_acc[NUM_CH-1], 33);
        load_zp('0);
        run_drain(MODE_PARALLEL, 0, 0, 1'b0, '0);

        // READ single word
        rand_stim(); capture(1'b0);
        rand_stim(); capture(1'b1);
        load_zp($urandom);
        run_drain(MODE_READ, 5, 0, 1'b0, '0);

        // Backpressure pattern
        rand_stim(); capture(1'b0);
        rand_stim(); capture(1'b1);
        load_zp($urandom);
        run_drain(MODE_RBR, 0, 1, 1'b0, '0);

        // Saturation at both ends
        for (int c = 0; c < NUM_CH; c++) stim_ch[c] = 32'h8000_0010;
        capture(1'b0);
        for (int c = 0; c < NUM_CH; c++) stim_ch[c] = '0;
        capture(1'b1);
        load_zp(32'd100);
        check("sat_neg_model", model_word(m_acc[0], m_zp), 32'h8000_0000);
        run_drain(MODE_READ, 0, 0, 1'b0, '0);
        for (int c = 0; c < NUM_CH; c++) stim_ch[c] = 32'h7FFF_FFF0;
        capture(1'b0);
        for (int c = 0; c < NUM_CH; c++) stim_ch[c] = '0;
        capture(1'b1);
        load_zp(-32'sd100);
        run_drain(MODE_PARALLEL, 0, 0, 1'b0, '0);

        // Protocol errors
        cap2 = 1'b1; tick(); cap2 = 1'b0;
        check("err_cap2_idle", err, 1);
        check("err_cap2_full", full, 0);
        pulse_flush();
        check("flush_err", err, 0);
        drain = 1'b1; tick(); drain = 1'b0;
        check("err_drain_idle", err, 1);
        check("drain_idle_valid", out_valid, 0);
        pulse_flush();

        rand_stim(); capture(1'b0);
        cap1 = 1'b1; cap2 = 1'b1; tick(); cap1 = 1'b0; cap2 = 1'b0;
        check("err_both_caps", err, 1);
        check("both_caps_full", full, 0);
        pulse_flush();

        rand_stim(); capture(1'b0);
        rand_stim(); capture(1'b1);
        check("pre_reserved_err", err, 0);
        mode = 3'b000; drain = 1'b1; tick(); drain = 1'b0;
        check("err_reserved", err, 1);
        check("reserved_full", full, 1);
        check("reserved_valid", out_valid, 0);

        // Flush mid-drain
        mode = MODE_PARALLEL; drain = 1'b1; tick(); drain = 1'b0;
        check("fl_valid", out_valid, 1);
        out_ready = 1'b1;
        repeat (3) tick();
        flush = 1'b1; tick(); flush = 1'b0; out_ready = 1'b0;
        check("fl_valid0", out_valid, 0);
        check("fl_last0", out_last, 0);
        check("fl_done0", done, 0);
        check("fl_err0", err, 0);
        check("fl_full0", full, 0);
        tick();
        check("fl_still_idle", out_valid, 0);
        drain = 1'b1; mode = MODE_PARALLEL; tick(); drain = 1'b0;
        check("fl_drain_err", err, 1);
        check("fl_drain_valid", out_valid, 0);
        pulse_flush();

        // zp change mid-drain takes effect only on the next drain
        rand_stim(); capture(1'b0);
        rand_stim(); capture(1'b1);
        load_zp($urandom);
        run_drain(MODE_PARALLEL, 0, 2, 1'b1, $urandom);
        rand_stim(); capture(1'b0);
        rand_stim(); capture(1'b1);
        run_drain(MODE_RBR, 0, 0, 1'b0, '0);

        // Random transactions
        for (int it = 0; it < 8; it++) begin
            logic [2:0] md;
            rand_stim(); capture(1'b0);
            if ($urandom_range(0, 1) == 1) begin
                rand_stim(); capture(1'b0);
            end
            rand_stim(); capture(1'b1);
            if ($urandom_range(0, 1) == 1) load_zp($urandom);
            case ($urandom_range(0, 2))
                0:       md = MODE_READ;
                1:       md = MODE_PARALLEL;
                default: md = MODE_RBR;
            endcase
            run_drain(md, int'($urandom_range(0, NUM_CH - 1)), 2, 1'b0, '0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
